uart_rx_ctrl: RTL
=================

Name: uart_rx_ctrl

Overview:
Control and buffering block that sits beside UART_RX. It owns the receiver's configuration (Prescale, PAR_EN, PAR_TYP) and applies changes only while the serial line is idle. It tracks frame activity on RX_IN with a timeout that recovers from corrupted frames. It buffers completed bytes (data_valid/P_DATA) in a small FIFO drained through a valid/ready read port.

Parameters:
DATA_WIDTH, 8, width of P_DATA and of each FIFO entry
PRESCALE_WIDTH, 6, width of Prescale and cfg_prescale
FIFO_DEPTH, 4, FIFO entries; power of two, at least 2
ADDR_WIDTH, 2, log2(FIFO_DEPTH)

Ports:
CLK  in  1  system clock
RST  in  1  synchronous active-high reset
RX_IN  in  1  serial line, monitored only; same signal feeds UART_RX
cfg_valid  in  1  config request
cfg_ready  out  1  config accept; combinational
cfg_prescale  in  PRESCALE_WIDTH  requested oversampling (8, 16 or 32)
cfg_par_en  in  1  requested parity enable
cfg_par_typ  in  1  requested parity type (0 even, 1 odd)
cfg_err  out  1  one-cycle pulse when an illegal prescale is rejected
Prescale  out  PRESCALE_WIDTH  to UART_RX
PAR_EN  out  1  to UART_RX
PAR_TYP  out  1  to UART_RX
rx_data_valid  in  1  UART_RX data_valid
rx_p_data  in  DATA_WIDTH  UART_RX P_DATA
rd_valid  out  1  FIFO non-empty
rd_ready  in  1  consumer pop
rd_data  out  DATA_WIDTH  FIFO head (first-word fall-through)
fifo_count  out  ADDR_WIDTH+1  occupancy, 0..FIFO_DEPTH
overrun  out  1  sticky: byte dropped because FIFO full
ovr_clr  in  1  clears overrun
busy  out  1  frame in progress
frame_timeout  out  1  one-cycle pulse on frame abandon

Behaviour:
- Reset (RST=1 at a CLK edge) overrides everything:
  - Prescale=8, PAR_EN=0, PAR_TYP=0.
  - cfg_err=0, frame_timeout=0, busy=0.
  - fifo_count=0, rd_valid=0, overrun=0.
  - FSM=IDLE; rx_in_q=1.
- rx_in_q is RX_IN registered each cycle. A falling edge is rx_in_q=1 and RX_IN=0.
- FSM states:
  - IDLE: on falling edge go to FRAME and clear frame counter fc to 0.
  - FRAME: fc increments each cycle.
    - rx_data_valid=1 goes to IDLE.
    - Otherwise, when fc == Prescale*(11+PAR_EN)-1, pulse frame_timeout for one cycle and go to IDLE.
    - rx_data_valid on the limit cycle wins: IDLE, no timeout pulse.
  - fc width is PRESCALE_WIDTH+4. Limit arithmetic is done at that width with no truncation (32*12-1 = 383).
- busy = (state==FRAME).
- Config handshake:
  - cfg_ready = (state==IDLE) && RX_IN==1 && !RST. No config change is possible once the line drops.
  - A transfer occurs when cfg_valid && cfg_ready.
  - Legal cfg_prescale (8, 16 or 32): Prescale/PAR_EN/PAR_TYP update at that edge and are visible the next cycle.
  - Illegal cfg_prescale: outputs unchanged and cfg_err=1 the next cycle for exactly one cycle. PAR_EN/PAR_TYP are also not applied.
  - Config outputs are stable at all other times.
- FIFO:
  - Push = rx_data_valid, in any FSM state.
  - Pop = rd_valid && rd_ready.
  - Push accepted if fifo_count<FIFO_DEPTH, or if a pop occurs the same cycle.
  - Push+pop with count 0 < count < DEPTH: count unchanged; data ordering preserved.
  - Push while full without pop: byte dropped, overrun set next cycle.
  - rd_valid = (fifo_count!=0). rd_data shows the head, valid the cycle after the first push.
  - Pop when empty has no effect.
  - Pointers wrap modulo FIFO_DEPTH.
- overrun: set on a dropped push and cleared by ovr_clr. Set and clear in the same cycle leaves it set.
- Reset mid-frame: FSM returns to IDLE, FIFO is emptied, config returns to defaults. No timeout pulse is generated.

Test Plan:
1. Reset, then cfg_prescale=16, par_en=1, par_typ=1 with RX_IN=1 -> cfg_ready=1; next cycle Prescale=16, PAR_EN=1, PAR_TYP=1; cfg_err=0.
2. cfg_prescale=12 -> cfg_err high exactly one cycle; Prescale stays 16. Then drive RX_IN low with cfg_valid held -> cfg_ready=0, no update.
3. Prescale=8, PAR_EN=0: RX_IN falls, no rx_data_valid -> busy for 88 cycles; frame_timeout pulses on the 88th FRAME cycle (fc=87); FSM back to IDLE.
4. Push 0xA5, 0x3C, 0xFF, 0x01 with rd_ready=0 -> fifo_count=4, rd_data=0xA5. Push 0x77 -> dropped, overrun=1. Pop all -> 0xA5, 0x3C, 0xFF, 0x01 in order, then rd_valid=0.
5. FIFO full with rd_ready=1 and push 0x55 in the same cycle -> count stays 4; 0x55 is read last. ovr_clr together with a dropped push -> overrun stays 1.
6. RST asserted mid-frame with 2 bytes buffered -> next cycle busy=0, fifo_count=0, Prescale=8, no frame_timeout pulse.

Source files
------------

// File: rtl/uart_rx_ctrl.sv
// Configuration, frame-activity tracking and receive-byte buffering beside UART_RX.
// Config changes are accepted only while the line is idle; completed bytes queue in a FWFT FIFO.
module uart_rx_ctrl #(
  parameter int unsigned DATA_WIDTH     = 8,
  parameter int unsigned PRESCALE_WIDTH = 6,
  parameter int unsigned FIFO_DEPTH     = 4,
  parameter int unsigned ADDR_WIDTH     = 2
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      RX_IN,
  input  logic                      cfg_valid,
  output logic                      cfg_ready,
  input  logic [PRESCALE_WIDTH-1:0] cfg_prescale,
  input  logic                      cfg_par_en,
  input  logic                      cfg_par_typ,
  output logic                      cfg_err,
  output logic [PRESCALE_WIDTH-1:0] Prescale,
  output logic                      PAR_EN,
  output logic                      PAR_TYP,
  input  logic                      rx_data_valid,
  input  logic [DATA_WIDTH-1:0]     rx_p_data,
  output logic                      rd_valid,
  input  logic                      rd_ready,
  output logic [DATA_WIDTH-1:0]     rd_data,
  output logic [ADDR_WIDTH:0]       fifo_count,
  output logic                      overrun,
  input  logic                      ovr_clr,
  output logic                      busy,
  output logic                      frame_timeout
);

  localparam int unsigned FC_W = PRESCALE_WIDTH + 4;
  localparam logic [ADDR_WIDTH:0] FULL = (ADDR_WIDTH + 1)'(FIFO_DEPTH);

  typedef enum logic {IDLE, FRAME} state_t;

  state_t                  state;
  logic                    rx_in_q;
  logic [FC_W-1:0]         fc;
  logic [FC_W-1:0]         fc_limit;
  logic                    fall;
  logic                    cfg_xfer;
  logic                    cfg_legal;
  logic                    at_limit;

  logic [DATA_WIDTH-1:0]   mem [FIFO_DEPTH];
  logic [ADDR_WIDTH-1:0]   wr_ptr;
  logic [ADDR_WIDTH-1:0]   rd_ptr;
  logic                    push;
  logic                    pop;
  logic                    drop;

  always_comb begin
    fall      = rx_in_q && !RX_IN;
    cfg_ready = (state == IDLE) && RX_IN && !RST;
    cfg_xfer  = cfg_valid && cfg_ready;
    cfg_legal = (cfg_prescale == PRESCALE_WIDTH'(8))  ||
                (cfg_prescale == PRESCALE_WIDTH'(16)) ||
                (cfg_prescale == PRESCALE_WIDTH'(32));
    // Full-width limit: 32 * 12 - 1 = 383 must not truncate.
    fc_limit  = FC_W'(Prescale) * (PAR_EN ? FC_W'(12) : FC_W'(11)) - FC_W'(1);
    at_limit  = (state == FRAME) && (fc == fc_limit);
    // A byte arriving on the limit cycle completes the frame instead of abandoning it.
    frame_timeout = at_limit && !rx_data_valid && !RST;
    busy      = (state == FRAME);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= IDLE;
      rx_in_q  <= 1'b1;
      fc       <= '0;
      Prescale <= PRESCALE_WIDTH'(8);
      PAR_EN   <= 1'b0;
      PAR_TYP  <= 1'b0;
      cfg_err  <= 1'b0;
    end else begin
      rx_in_q <= RX_IN;
      cfg_err <= cfg_xfer && !cfg_legal;
      if (cfg_xfer && cfg_legal) begin
        Prescale <= cfg_prescale;
        PAR_EN   <= cfg_par_en;
        PAR_TYP  <= cfg_par_typ;
      end
      case (state)
        IDLE: begin
          if (fall) begin
            state <= FRAME;
            fc    <= '0;
          end
        end
        FRAME: begin
          if (rx_data_valid || at_limit) state <= IDLE;
          else                           fc    <= fc + FC_W'(1);
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    rd_valid = (fifo_count != '0);
    rd_data  = mem[rd_ptr];
    pop      = rd_valid && rd_ready;
    push     = rx_data_valid && ((fifo_count != FULL) || pop);
    drop     = rx_data_valid && !push;
  end

  always_ff @(posedge CLK) begin
    if (push) mem[wr_ptr] <= rx_p_data;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      overrun    <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
      if (pop)  rd_ptr <= rd_ptr + ADDR_WIDTH'(1);
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + (ADDR_WIDTH + 1)'(1);
        2'b01:   fifo_count <= fifo_count - (ADDR_WIDTH + 1)'(1);
        default: fifo_count <= fifo_count;
      endcase
      if (drop)         overrun <= 1'b1;
      else if (ovr_clr) overrun <= 1'b0;
    end
  end

endmodule
